// File: rtl/string_tx.sv
// string_tx: DEPTH-slot nibble FIFO feeding an MSB-first serialiser, BIT_DIV clocks per bit.
// Optional feature macro STRING_TX_PARITY_EN appends an even-parity bit after each nibble.
module string_tx #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned BIT_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] din,
   input  logic       load,
   input  logic       start,
   input  logic       abort,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       busy,
   output logic       empty,
   output logic       full,
   output logic [6:0] bits_sent,
   output logic       frame_done
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef STRING_TX_PARITY_EN
   localparam int unsigned NB = 5;
`else
   localparam int unsigned NB = 4;
`endif
   localparam logic [7:0]  DivLast = 8'(BIT_DIV - 1);
   localparam logic [2:0]  IdxTop  = 3'(NB - 1);
   localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

   state_e          state_q, state_d;
   logic [3:0]      mem [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     count_q;
   logic [NB-1:0]   sreg_q;
   logic [NB-1:0]   head_bits;
   logic [2:0]      idx_q;
   logic [7:0]      cnt_q;
   logic [6:0]      bits_q;
   logic            push, pop, start_ok, period_end;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CntFull);
   assign bits_sent = bits_q;

   assign pop        = (state_q == StFetch);
   // A pop in the same cycle frees a slot, so a load into a full FIFO still lands.
   assign push       = load && (!full || pop);
   assign start_ok   = (state_q == StIdle) && start && !empty;
   assign period_end = (state_q == StShift) && (cnt_q == DivLast);

`ifdef STRING_TX_PARITY_EN
   assign head_bits = {mem[rptr_q], ^mem[rptr_q]};
`else
   assign head_bits = mem[rptr_q];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:  if (start && !empty) state_d = StFetch;
            StFetch: state_d = StShift;
            StShift: if (period_end && idx_q == '0) state_d = empty ? StDone : StFetch;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy       = (state_q != StIdle);
      frame_done = (state_q == StDone);
      bit_valid  = (state_q == StShift) && (cnt_q == '0);
      bit_out    = (state_q == StIdle) ? 1'b0 : sreg_q[NB-1];
   end

   always_ff @(posedge clk) begin
      if (push && !abort) mem[wptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (abort) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // The last bit of a nibble is not shifted out, so bit_out holds through FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
         bits_q <= '0;
      end else if (abort) begin
         sreg_q <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
      end else begin
         if (start_ok) begin
            sreg_q <= '0;
            bits_q <= '0;
         end
         if (pop) begin
            sreg_q <= head_bits;
            idx_q  <= IdxTop;
            cnt_q  <= '0;
         end else if (state_q == StShift) begin
            if (cnt_q == DivLast) begin
               cnt_q <= '0;
               if (idx_q != '0) begin
                  idx_q  <= idx_q - 3'd1;
                  sreg_q <= {sreg_q[NB-2:0], 1'b0};
               end
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
         if (bit_valid && bits_q != 7'h7f) bits_q <= bits_q + 7'd1;
      end
   end

endmodule

// File: tb/tb_string_tx.sv
// Bench for string_tx: directed scenarios with random nibble data, checked against a
// frame model built from the list of accepted nibbles (bit order, bit timing, counters).
module tb_string_tx;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned BIT_DIV = 4;
`ifdef STRING_TX_PARITY_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] din;
   logic       load, start, abort;
   logic       bit_out, bit_valid, busy, empty, full, frame_done;
   logic [6:0] bits_sent;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int fd_cnt = 0;
   logic       got_bit [$];
   int         got_cyc [$];
   logic [3:0] exp_nib [$];

   string_tx #(.DEPTH(DEPTH), .BIT_DIV(BIT_DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .load       (load),
      .start      (start),
      .abort      (abort),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .empty      (empty),
      .full       (full),
      .bits_sent  (bits_sent),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bit_valid === 1'b1) begin
         got_bit.push_back(bit_out);
         got_cyc.push_back(cyc);
      end
      if (frame_done === 1'b1) fd_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed hang required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sync();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_bit.delete();
      got_cyc.delete();
      exp_nib.delete();
      fd_cnt = 0;
   endtask

   // Load while idle; the model accepts only while fewer than DEPTH nibbles are queued.
   task automatic load_idle(input logic [3:0] v);
      din  = v;
      load = 1'b1;
      step();
      load = 1'b0;
      if (exp_nib.size() < DEPTH) exp_nib.push_back(v);
   endtask

   task automatic load_run(input logic [3:0] v);
      din  = v;
      load = 1'b1;
      step();
      load = 1'b0;
      exp_nib.push_back(v);
   endtask

   task automatic kick(output int c);
      c     = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_bits(input int n);
      for (int i = 0; i < 500 && got_bit.size() < n; i++) sync();
      chk("wait_bits", 32'(got_bit.size() >= n), 32'd1);
   endtask

   // Bit k of the frame: first bit two clocks after start, BIT_DIV apart, plus one
   // FETCH clock between nibbles.
   task automatic check_frame(input string tag, input int c);
      int k;
      int total;
      logic [3:0] v;
      logic eb;
      for (int i = 0; i < 2000 && busy === 1'b1; i++) sync();
      repeat (2) sync();
      total = NB * exp_nib.size();
      chk({tag, ".nbits"}, got_bit.size(), total);
      k = 0;
      foreach (exp_nib[n]) begin
         v = exp_nib[n];
         for (int b = 0; b < NB; b++) begin
            eb = (b < 4) ? v[3 - b] : ^v;
            if (k < got_bit.size()) begin
               chk($sformatf("%s.bit%0d", tag, k), got_bit[k], eb);
               chk($sformatf("%s.cyc%0d", tag, k), got_cyc[k],
                   c + 2 + k * BIT_DIV + k / NB);
            end
            k++;
         end
      end
      chk({tag, ".frame_done"}, fd_cnt, 1);
      chk({tag, ".bits_sent"}, bits_sent, (total > 127) ? 127 : total);
      chk({tag, ".empty"}, empty, 1'b1);
      chk({tag, ".busy"}, busy, 1'b0);
      clear_mon();
   endtask

   initial begin
      int c;
      int n;
      logic [3:0] v;
      rst_n = 1'b0;
      din   = '0;
      load  = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      #12;
      chk("rst.busy", busy, 1'b0);
      chk("rst.empty", empty, 1'b1);
      chk("rst.full", full, 1'b0);
      chk("rst.bit_out", bit_out, 1'b0);
      chk("rst.bit_valid", bit_valid, 1'b0);
      chk("rst.bits_sent", bits_sent, 7'd0);
      chk("rst.frame_done", frame_done, 1'b0);
      #5 rst_n = 1'b1;
      step();
      clear_mon();

      // Single nibble 0xA.
      load_idle(4'hA);
      kick(c);
      check_frame("single_a", c);

      // Fill, overflow attempt, drain.
      load_idle(4'h3);
      load_idle(4'hC);
      load_idle(4'h5);
      load_idle(4'h9);
      sync();
      chk("fill.full", full, 1'b1);
      load_idle(4'hF);
      sync();
      chk("fill.full_after_extra", full, 1'b1);
      kick(c);
      check_frame("fill", c);

      // Load during the second nibble's transmission joins the same frame.
      load_idle(4'($urandom));
      load_idle(4'($urandom));
      kick(c);
      wait_bits(NB + 1);
      load_run(4'($urandom));
      check_frame("midload", c);

      // Random frames.
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) load_idle(4'($urandom));
         kick(c);
         check_frame($sformatf("rand%0d", r), c);
      end

      // Abort during the second bit of the first nibble.
      load_idle(4'($urandom));
      load_idle(4'($urandom));
      kick(c);
      wait_bits(2);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      sync();
      chk("abort.busy", busy, 1'b0);
      chk("abort.empty", empty, 1'b1);
      repeat (10) sync();
      chk("abort.frame_done", fd_cnt, 0);
      chk("abort.bits_sent", bits_sent, 7'd2);
      chk("abort.bit_out", bit_out, 1'b0);
      clear_mon();

      // Asynchronous reset mid-frame, then a start with the FIFO empty.
      load_idle(4'($urandom));
      load_idle(4'($urandom));
      kick(c);
      wait_bits(3);
      #1 rst_n = 1'b0;
      #1;
      chk("arst.busy", busy, 1'b0);
      chk("arst.empty", empty, 1'b1);
      chk("arst.bits_sent", bits_sent, 7'd0);
      chk("arst.bit_valid", bit_valid, 1'b0);
      chk("arst.bit_out", bit_out, 1'b0);
      repeat (2) step();
      #2 rst_n = 1'b1;
      step();
      kick(c);
      for (int i = 0; i < 3; i++) begin
         sync();
         chk($sformatf("arst.idle_start%0d", i), busy, 1'b0);
      end
      chk("arst.frame_done", fd_cnt, 0);
      clear_mon();

      // Load into a full FIFO in the FETCH cycle is accepted.
      for (int i = 0; i < DEPTH; i++) load_idle(4'($urandom));
      sync();
      chk("fetchload.full_before", full, 1'b1);
      kick(c);
      v = 4'($urandom);
      din  = v;
      load = 1'b1;
      step();
      load = 1'b0;
      exp_nib.push_back(v);
      sync();
      chk("fetchload.full_after", full, 1'b1);
      check_frame("fetchload", c);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/string_tx.md
STRING_TX -- requirements
Module: string_tx

Interface
REQ-001 Parameter DEPTH, default 4, number of 4-bit nibble slots in the transmit FIFO (power of two, 2..16).
REQ-002 Parameter BIT_DIV, default 4, clock cycles per transmitted bit (1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 din  input  4  nibble to enqueue.
REQ-006 load  input  1  one-cycle pulse; enqueue din.
REQ-007 start  input  1  one-cycle pulse; begin serialising FIFO contents.
REQ-008 abort  input  1  synchronous stop; flush FIFO, return to IDLE.
REQ-009 bit_out  output  1  serial data, MSB of each nibble first.
REQ-010 bit_valid  output  1  high for the first clk of each bit period.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 empty  output  1  FIFO holds no nibbles.
REQ-013 full  output  1  FIFO holds DEPTH nibbles.
REQ-014 bits_sent  output  7  bits transmitted since the last start, saturating at 127.
REQ-015 frame_done  output  1  one-cycle pulse after the last bit of the last nibble.

Function
REQ-016 FIFO: circular buffer with write/read pointers and occupancy count; load while full is ignored, no state change.
REQ-017 load is accepted in any state, including during transmission; a nibble enqueued before the FIFO drains is sent in the same frame.
REQ-018 FSM states IDLE, FETCH, SHIFT, DONE.
REQ-019 IDLE: bit_out=0; start with !empty -> FETCH; start with empty is ignored.
REQ-020 FETCH (1 clk): pop head nibble into the 4-bit shift register, bit index=3, bit-period counter=0 -> SHIFT.
REQ-021 SHIFT: bit_out = shift register MSB held for BIT_DIV clks; bit_valid pulses on counter==0; bits_sent increments on the same cycle as bit_valid.
REQ-022 Bit index 0 with period complete: !empty -> FETCH; empty -> DONE.
REQ-023 DONE (1 clk): frame_done=1 -> IDLE.
REQ-024 Latency: first bit_valid exactly 2 clks after the start pulse is sampled; gap between nibbles is 1 clk (FETCH), with bit_out held at the previous value.
REQ-025 start while busy is ignored; bits_sent clears only on an accepted start.
REQ-026 abort has priority over load and start: pointers and count clear, state -> IDLE, bit_out=0, no frame_done; bits_sent holds its value.
REQ-027 Simultaneous load and FIFO pop: both occur; count is unchanged; a load when full coincident with a pop is accepted.
REQ-028 Pointers wrap modulo DEPTH.

Reset
REQ-029 rst_n low asynchronously forces IDLE, pointers/count=0, shift register=0, bit_out=0, bit_valid=0, busy=0, empty=1, full=0, bits_sent=0, frame_done=0.
REQ-030 Reset mid-frame discards the frame with no frame_done; operation resumes on the first clk edge after release.

Configuration
REQ-031 Macro STRING_TX_PARITY_EN: when defined, each nibble is followed by one even-parity bit (XOR of the 4 data bits) with full bit_valid/BIT_DIV timing, counted in bits_sent; when undefined, nibbles are sent back to back with no parity bit and 4 bits per nibble.

Verification
REQ-032 BIT_DIV=4, load 0xA then start -> bit_out 1,0,1,0 each 4 clks, first bit_valid 2 clks after start, frame_done once, bits_sent=4 (5 with parity, parity bit 0).
REQ-033 Load 0x3,0xC,0x5,0x9 (full=1), 5th load 0xF -> ignored; start -> 16 bits 0011 1100 0101 1001, empty=1 at end.
REQ-034 Start, load 0x7 during the second nibble's SHIFT -> 0x7 sent in the same frame, single frame_done.
REQ-035 abort during bit 2 of the first nibble -> busy=0 and empty=1 next clk, no frame_done, bits_sent frozen at 2.
REQ-036 rst_n low mid-frame, asynchronous to clk -> all outputs reach reset values immediately; start with empty after release -> busy stays 0.
REQ-037 Full FIFO: load coincident with a FETCH pop -> accepted, full stays 1, all 5 nibbles transmitted in order.
